seg_scan_ctrl: RTL and testbench

Parametrised multiplexed 7-segment scan controller. It drives DIGITS common-anode digits from a packed hex word. It derives the scan rate from the system clock and double-buffers the display data so updates take effect only at frame boundaries (no tearing). It adds per-digit decimal points, optional leading-zero suppression, an inter-digit anti-ghost blanking gap and a frame-done pulse. It sits between the datapath (register/ALU result bus) and the board anode/segment pins.

---
 rtl/seg_scan_ctrl.sv | 153 +++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed common-anode 7-segment scan controller.
// Scans DIGITS digits from a packed hex word. Display data is double-buffered
// so a new value only takes effect at a frame boundary, which avoids tearing.
`timescale 1ns/1ps

module seg_scan_ctrl #(
    parameter int DIGITS    = 8,
    parameter int TICK_DIV  = 100000,
    parameter int BLANK_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  lz_blank,
    input  logic                  enable,
    output logic [DIGITS-1:0]     an,
    output logic [7:0]            seg,
    output logic                  frame_done
);

    localparam int CW = $clog2(TICK_DIV);
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [CW-1:0]       cnt;
    logic [DW-1:0]       dig;
    logic                cnt_last;
    logic                boundary;

    logic [4*DIGITS-1:0] shadow_data;
    logic [DIGITS-1:0]   shadow_dp;
    logic [4*DIGITS-1:0] pend_data;
    logic [DIGITS-1:0]   pend_dp;
    logic                pend;

    logic [DIGITS-1:0]   blank_vec;
    logic                zero_above;
    logic [3:0]          nibble;
    logic                dp_cur;
    logic                blank_cur;
    logic [DIGITS-1:0]   an_act;
    logic [DIGITS-1:0]   an_nxt;
    logic [7:0]          seg_nxt;

    assign cnt_last = (cnt == CW'(TICK_DIV - 1));
    assign boundary = cnt_last && (dig == DW'(DIGITS - 1));

    // Font lookup for segments a..g, active low.
    function automatic logic [6:0] font(input logic [3:0] n);
        case (n)
            4'h0: font = 7'b0000001;
            4'h1: font = 7'b1001111;
            4'h2: font = 7'b0010010;
            4'h3: font = 7'b0000110;
            4'h4: font = 7'b1001100;
            4'h5: font = 7'b0100100;
            4'h6: font = 7'b0100000;
            4'h7: font = 7'b0001111;
            4'h8: font = 7'b0000000;
            4'h9: font = 7'b0000100;
            4'hA: font = 7'b0001000;
            4'hB: font = 7'b1100000;
            4'hC: font = 7'b0110001;
            4'hD: font = 7'b1000010;
            4'hE: font = 7'b0110000;
            default: font = 7'b0111000;
        endcase
    endfunction

    // Slot counter and digit index; a digit advances at the end of each slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            dig <= '0;
        end else if (cnt_last) begin
            cnt <= '0;
            dig <= (dig == DW'(DIGITS - 1)) ? '0 : dig + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Double buffer: loads park in pending, shadow only changes at the frame edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_data <= '0;
            shadow_dp   <= '0;
            pend_data   <= '0;
            pend_dp     <= '0;
            pend        <= 1'b0;
        end else if (boundary) begin
            if (load) begin
                shadow_data <= data;
                shadow_dp   <= dp_in;
            end else if (pend) begin
                shadow_data <= pend_data;
                shadow_dp   <= pend_dp;
            end
            pend <= 1'b0;
        end else if (load) begin
            pend_data <= data;
            pend_dp   <= dp_in;
            pend      <= 1'b1;
        end
    end

    // Leading-zero mask: a digit blanks when it and every higher nibble is zero.
    always_comb begin
        zero_above = 1'b1;
        blank_vec  = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_above   = zero_above & (shadow_data[4*i +: 4] == 4'h0);
            blank_vec[i] = lz_blank & (i != 0) & zero_above;
        end
    end

    // Next anode/segment pattern for the current slot, blanking gap first.
    always_comb begin
        nibble    = shadow_data[{dig, 2'b00} +: 4];
        dp_cur    = shadow_dp[dig];
        blank_cur = blank_vec[dig];
        an_act    = ~(DIGITS'(1) << dig);
        an_nxt    = '1;
        seg_nxt   = 8'hFF;
        if (!enable || (cnt < CW'(BLANK_CYC))) begin
            an_nxt  = '1;
            seg_nxt = 8'hFF;
        end else if (blank_cur) begin
            if (dp_cur) begin
                an_nxt  = an_act;
                seg_nxt = 8'b11111110;
            end
        end else begin
            an_nxt  = an_act;
            seg_nxt = {font(nibble), ~dp_cur};
        end
    end

    // Registered pin drivers and the frame-start pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an         <= '1;
            seg        <= 8'hFF;
            frame_done <= 1'b0;
        end else begin
            an         <= an_nxt;
            seg        <= seg_nxt;
            frame_done <= boundary;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl with DIGITS=4,
// TICK_DIV=8, BLANK_CYC=2. Expected pin states are queued against a cycle
// number counted from reset release; a monitor pops and compares them.
`timescale 1ns/1ps

module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data;
    logic [3:0]  dp_in;
    logic        load;
    logic        lz_blank;
    logic        enable;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        frame_done;

    int errors = 0;
    int checks = 0;
    int cyc;

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [7:0] seg;
        logic       fd;
        string      name;
    } exp_t;

    exp_t sb[$];

    seg_scan_ctrl #(
        .DIGITS   (4),
        .TICK_DIV (8),
        .BLANK_CYC(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data      (data),
        .dp_in     (dp_in),
        .load      (load),
        .lz_blank  (lz_blank),
        .enable    (enable),
        .an        (an),
        .seg       (seg),
        .frame_done(frame_done)
    );

    // 10 ns system clock.
    always #5 clk = ~clk;

    // Cycle number since reset release; cycle n is the period with cnt-in-frame == n.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic checkOutput(input string name, input logic [3:0] a, input logic [7:0] s,
                               input logic f, input logic [3:0] ea, input logic [7:0] es,
                               input logic ef);
        checks++;
        if (a !== ea || s !== es || f !== ef) begin
            errors++;
            $display("[TB] FAIL %s: got an=%b seg=%b fd=%b, want an=%b seg=%b fd=%b",
                     name, a, s, f, ea, es, ef);
        end
    endtask

    task automatic expect_at(input int c, input logic [3:0] a, input logic [7:0] s,
                             input logic f, input string n);
        exp_t e;
        e.cyc  = c;
        e.an   = a;
        e.seg  = s;
        e.fd   = f;
        e.name = n;
        sb.push_back(e);
    endtask

    // Monitor: compare every queued expectation whose cycle has arrived.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                if (e.cyc < cyc) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL %s: stale entry for cycle %0d seen at cycle %0d",
                             e.name, e.cyc, cyc);
                end else begin
                    checkOutput($sformatf("%s@%0d", e.name, e.cyc), an, seg, frame_done,
                                e.an, e.seg, e.fd);
                end
            end
        end
    end

    task automatic applyStimulus(input int at_cyc, input logic [15:0] d, input logic [3:0] dp);
        @(negedge clk);
        while (cyc < at_cyc) @(negedge clk);
        data  = d;
        dp_in = dp;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        load     = 1'b0;
        data     = '0;
        dp_in    = '0;
        lz_blank = 1'b0;
        enable   = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: %0d expectations left unchecked, want 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset release, scan start, frame_done, mid-frame load shows next frame.
        do_reset();
        expect_at(0,  4'hF, 8'hFF, 1'b0, "rst_state");
        expect_at(1,  4'hF, 8'hFF, 1'b0, "gap_c1");
        expect_at(2,  4'hF, 8'hFF, 1'b0, "gap_c2");
        expect_at(3,  4'hE, 8'h03, 1'b0, "slot0_first");
        expect_at(8,  4'hE, 8'h03, 1'b0, "slot0_last");
        expect_at(9,  4'hF, 8'hFF, 1'b0, "slot1_gap");
        expect_at(12, 4'hD, 8'h03, 1'b0, "old_d1");
        expect_at(20, 4'hB, 8'h03, 1'b0, "old_d2");
        expect_at(28, 4'h7, 8'h03, 1'b0, "old_d3");
        expect_at(31, 4'h7, 8'h03, 1'b0, "fd_low");
        expect_at(32, 4'h7, 8'h03, 1'b1, "fd_pulse");
        expect_at(33, 4'hF, 8'hFF, 1'b0, "fd_one_cycle");
        expect_at(36, 4'hE, 8'h71, 1'b0, "new_d0_F");
        expect_at(44, 4'hD, 8'h11, 1'b0, "new_d1_A");
        expect_at(52, 4'hB, 8'h25, 1'b0, "new_d2_2");
        expect_at(60, 4'h7, 8'h9F, 1'b0, "new_d3_1");
        expect_at(64, 4'h7, 8'h9F, 1'b1, "fd_pulse2");
        applyStimulus(10, 16'h12AF, 4'b0000);
        drain();

        // Leading-zero suppression, then an all-zero word.
        do_reset();
        lz_blank = 1'b1;
        expect_at(36, 4'hE, 8'h03, 1'b0, "lz_d0");
        expect_at(44, 4'hD, 8'h49, 1'b0, "lz_d1_5");
        for (int c = 49; c <= 64; c++)
            expect_at(c, 4'hF, 8'hFF, (c == 64) ? 1'b1 : 1'b0, "lz_d23_dark");
        expect_at(68, 4'hE, 8'h03, 1'b0, "zero_d0");
        expect_at(76, 4'hF, 8'hFF, 1'b0, "zero_d1");
        expect_at(84, 4'hF, 8'hFF, 1'b0, "zero_d2");
        expect_at(92, 4'hF, 8'hFF, 1'b0, "zero_d3");
        expect_at(96, 4'hF, 8'hFF, 1'b1, "zero_fd");
        applyStimulus(2, 16'h0050, 4'b0000);
        applyStimulus(40, 16'h0000, 4'b0000);
        drain();

        // Blanked digit with its decimal point still lit.
        do_reset();
        lz_blank = 1'b1;
        expect_at(36, 4'hE, 8'h9F, 1'b0, "dp_d0_1");
        expect_at(44, 4'hF, 8'hFF, 1'b0, "dp_d1_dark");
        expect_at(52, 4'hF, 8'hFF, 1'b0, "dp_d2_dark");
        expect_at(57, 4'hF, 8'hFF, 1'b0, "dp_d3_gap");
        expect_at(59, 4'h7, 8'hFE, 1'b0, "dp_d3_on");
        expect_at(60, 4'h7, 8'hFE, 1'b0, "dp_d3_mid");
        applyStimulus(2, 16'h0001, 4'b1000);
        drain();

        // Load on the boundary cycle bypasses an older pending value.
        do_reset();
        expect_at(32, 4'h7, 8'h03, 1'b1, "byp_fd");
        expect_at(33, 4'hF, 8'hFF, 1'b0, "byp_gap");
        expect_at(36, 4'hE, 8'h99, 1'b0, "byp_d0_4");
        expect_at(44, 4'hD, 8'h0D, 1'b0, "byp_d1_3");
        expect_at(52, 4'hB, 8'h25, 1'b0, "byp_d2_2");
        expect_at(60, 4'h7, 8'h9F, 1'b0, "byp_d3_1");
        applyStimulus(5, 16'h5555, 4'b0000);
        applyStimulus(31, 16'h1234, 4'b0000);
        drain();

        // Two loads in one frame: last one wins.
        do_reset();
        expect_at(36, 4'hE, 8'h0D, 1'b0, "last_d0_3");
        expect_at(44, 4'hD, 8'h03, 1'b0, "last_d1_0");
        applyStimulus(5, 16'h000A, 4'b0000);
        applyStimulus(20, 16'h0003, 4'b0000);
        drain();

        // Async reset with a pending load, then one dark frame via enable.
        do_reset();
        expect_at(12, 4'hD, 8'h03, 1'b0, "pre_rst_d1");
        expect_at(44, 4'hD, 8'h03, 1'b0, "pre_rst_d1b");
        applyStimulus(34, 16'h0008, 4'b0001);
        while (cyc < 44) @(negedge clk);
        #1 rst = 1'b1;
        #1 checkOutput("async_reset", an, seg, frame_done, 4'hF, 8'hFF, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        expect_at(32, 4'h7, 8'h03, 1'b1, "post_rst_fd");
        expect_at(36, 4'hE, 8'h03, 1'b0, "pend_lost_d0");
        expect_at(44, 4'hD, 8'h03, 1'b0, "pend_lost_d1");
        expect_at(64, 4'h7, 8'h03, 1'b1, "pre_dark_fd");
        for (int c = 65; c <= 96; c++)
            expect_at(c, 4'hF, 8'hFF, (c == 96) ? 1'b1 : 1'b0, "dark_frame");
        expect_at(100, 4'hE, 8'h03, 1'b0, "relit_d0");
        while (cyc < 64) @(negedge clk);
        enable = 1'b0;
        while (cyc < 96) @(negedge clk);
        enable = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
